// File: rtl/uart_pkg.sv
// Shared constants for the UART peripheral: register map, CON bit layout,
// RX FIFO depth and TX state encodings.
package uart_pkg;

  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  localparam int CON_TX_FULL = 0;
  localparam int CON_TX_BUSY = 1;
  localparam int CON_RX_NE   = 2;
  localparam int CON_OVR     = 3;
  localparam int CON_RX_IE   = 4;
  localparam int CON_TX_IE   = 5;
  localparam int CON_TX_DONE = 6;

  localparam int DATA_W        = 8;
  localparam int RX_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with combinational head; push while full is accepted
// only when a pop happens on the same edge.
module uart_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped UART front end: TX holding register + start FSM, RX FIFO, CON.
// Interrupt logic and CON bits 6:4 exist only when UART_IRQ_EN is defined.
module uart_periph
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              wr,
  input  logic              rd,
  output logic [31:0]       rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_en,
  input  logic              tx_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              irq
);

  logic sel_txd, sel_rxd, sel_con;
  logic txd_wr, con_wr, rxd_rd, txd_accept;

  tx_state_e         state_q, state_d;
  logic              tx_load;
  logic              hold_clr;
  logic              hold_full;
  logic [DATA_W-1:0] hold_byte;
  logic [DATA_W-1:0] tx_data_q;

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              ovr_q;

  logic              rx_ie_q, tx_ie_q, done_q, irq_q;
  logic [31:0]       con_val;
  logic [23:0]       unused_wdata;

  assign sel_txd    = (addr == ADDR_TXD);
  assign sel_rxd    = (addr == ADDR_RXD);
  assign sel_con    = (addr == ADDR_CON);
  assign txd_wr     = wr & sel_txd;
  assign con_wr     = wr & sel_con;
  assign rxd_rd     = rd & sel_rxd;
  assign txd_accept = txd_wr & ~hold_full;
  assign unused_wdata = wdata[31:8];

  // A write accepted while idle starts the frame on the same edge it fills
  // the holding register, so tx_en follows the write by one cycle.
  always_comb begin
    state_d  = state_q;
    tx_load  = 1'b0;
    hold_clr = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (hold_full || txd_accept) begin
          state_d = TX_START;
          tx_load = 1'b1;
        end
      end
      TX_START: begin
        state_d  = TX_WAIT;
        hold_clr = 1'b1;
      end
      TX_WAIT: begin
        if (tx_done) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      hold_full <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (txd_accept)    hold_full <= 1'b1;
      else if (hold_clr) hold_full <= 1'b0;
      if (tx_load) tx_data_q <= txd_accept ? wdata[DATA_W-1:0] : hold_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (txd_accept) hold_byte <= wdata[DATA_W-1:0];
  end

  assign tx_en   = (state_q == TX_START);
  assign tx_data = tx_data_q;

  uart_fifo #(
    .DEPTH  (RX_FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (rxd_rd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Sticky set wins over a software clear on the same edge.
  always_ff @(posedge clk) begin
    if (rst) ovr_q <= 1'b0;
    else     ovr_q <= (rx_valid & fifo_full & ~rxd_rd) |
                      (ovr_q & ~(con_wr & wdata[CON_OVR]));
  end

`ifdef UART_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ie_q <= 1'b0;
      tx_ie_q <= 1'b0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (con_wr) begin
        rx_ie_q <= wdata[CON_RX_IE];
        tx_ie_q <= wdata[CON_TX_IE];
      end
      done_q <= tx_done | (done_q & ~(con_wr & wdata[CON_TX_DONE]));
      irq_q  <= (rx_ie_q & ~fifo_empty) | (tx_ie_q & done_q);
    end
  end
`else
  assign rx_ie_q = 1'b0;
  assign tx_ie_q = 1'b0;
  assign done_q  = 1'b0;
  assign irq_q   = 1'b0;
`endif

  assign irq = irq_q;

  always_comb begin
    con_val              = '0;
    con_val[CON_TX_FULL] = hold_full;
    con_val[CON_TX_BUSY] = (state_q != TX_IDLE);
    con_val[CON_RX_NE]   = ~fifo_empty;
    con_val[CON_OVR]     = ovr_q;
    con_val[CON_RX_IE]   = rx_ie_q;
    con_val[CON_TX_IE]   = tx_ie_q;
    con_val[CON_TX_DONE] = done_q;
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_rxd && !fifo_empty) rdata = {24'd0, fifo_head};
      else if (sel_con)           rdata = con_val;
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// Directed self-checking bench for uart_periph: a register-access vector
// table plus hand sequences for TX timing, interrupts and reset.
module tb_uart_periph;

  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;
`ifdef UART_IRQ_EN
  localparam logic [31:0] EN_BITS = 32'h30;
  localparam logic [31:0] DONE    = 32'h40;
`else
  localparam logic [31:0] EN_BITS = 32'h00;
  localparam logic [31:0] DONE    = 32'h00;
`endif

  logic        clk = 1'b0;
  logic        rst, wr, rd, tx_done, rx_valid, tx_en, irq;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  tx_data, rx_data;

  int checks = 0;
  int errors = 0;

  uart_periph dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr(wr), .rd(rd),
    .rdata(rdata), .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done),
    .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef enum int { OP_RD, OP_NORD, OP_WR, OP_RX, OP_RXRD, OP_RXWR } op_e;
  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  rxb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input op_e op, input logic [31:0] a,
                              input logic [31:0] d, input logic [7:0] b,
                              input logic [31:0] e);
    vec_t v;
    v.op = op; v.addr = a; v.wdata = d; v.rxb = b; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a; rd = 1'b1;
    #1 check(name, rdata, exp);
    tick();
    rd = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic expect_no_tx(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      check(name, {31'd0, tx_en}, 32'd0);
      tick();
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      addr = v.addr; wdata = v.wdata; rx_data = v.rxb;
      case (v.op)
        OP_RD:   rd = 1'b1;
        OP_NORD: rd = 1'b0;
        OP_WR:   wr = 1'b1;
        OP_RX:   rx_valid = 1'b1;
        OP_RXRD: begin rd = 1'b1; rx_valid = 1'b1; end
        OP_RXWR: begin wr = 1'b1; rx_valid = 1'b1; end
        default: ;
      endcase
      #1;
      if (v.op == OP_RD || v.op == OP_NORD || v.op == OP_RXRD)
        check($sformatf("vec%0d_rdata", i), rdata, v.exp);
      tick();
      rd = 1'b0; wr = 1'b0; rx_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; tx_done = 1'b0; rx_valid = 1'b0;
    addr = '0; wdata = '0; rx_data = '0;

    // Register/FIFO access table.
    vecs.push_back(mk(OP_RD,   A_CON, 0, 0, 32'h00));
    vecs.push_back(mk(OP_RD,   A_RXD, 0, 0, 32'h00));
    vecs.push_back(mk(OP_RD,   A_TXD, 0, 0, 32'h00));
    vecs.push_back(mk(OP_RD,   32'h4000_0024, 0, 0, 32'h00));
    vecs.push_back(mk(OP_RD,   32'h0000_0020, 0, 0, 32'h00));
    vecs.push_back(mk(OP_WR,   A_RXD, 32'hFF, 0, 0));
    vecs.push_back(mk(OP_RD,   A_CON, 0, 0, 32'h00));
    for (int k = 1; k <= 5; k++) vecs.push_back(mk(OP_RX, 0, 0, 8'hA0 + 8'(k), 0));
    vecs.push_back(mk(OP_NORD, A_RXD, 0, 0, 32'h00));
    vecs.push_back(mk(OP_NORD, A_CON, 0, 0, 32'h00));
    vecs.push_back(mk(OP_RD,   A_CON, 0, 0, 32'h0C));
    for (int k = 1; k <= 4; k++) vecs.push_back(mk(OP_RD, A_RXD, 0, 0, 32'hA0 + k));
    vecs.push_back(mk(OP_RD,   A_RXD, 0, 0, 32'h00));
    vecs.push_back(mk(OP_RD,   A_CON, 0, 0, 32'h08));
    vecs.push_back(mk(OP_WR,   A_CON, 32'h08, 0, 0));
    vecs.push_back(mk(OP_RD,   A_CON, 0, 0, 32'h00));
    for (int k = 1; k <= 4; k++) vecs.push_back(mk(OP_RX, 0, 0, 8'hB0 + 8'(k), 0));
    vecs.push_back(mk(OP_RXRD, A_RXD, 0, 8'hB0, 32'hB1));
    vecs.push_back(mk(OP_RD,   A_CON, 0, 0, 32'h04));
    vecs.push_back(mk(OP_RD,   A_RXD, 0, 0, 32'hB2));
    vecs.push_back(mk(OP_RD,   A_RXD, 0, 0, 32'hB3));
    vecs.push_back(mk(OP_RD,   A_RXD, 0, 0, 32'hB4));
    vecs.push_back(mk(OP_RD,   A_RXD, 0, 0, 32'hB0));
    vecs.push_back(mk(OP_RD,   A_RXD, 0, 0, 32'h00));
    vecs.push_back(mk(OP_RX,   0, 0, 8'hC1, 0));
    vecs.push_back(mk(OP_RXRD, A_RXD, 0, 8'hC2, 32'hC1));
    vecs.push_back(mk(OP_RXRD, A_RXD, 0, 8'hC3, 32'hC2));
    vecs.push_back(mk(OP_RD,   A_CON, 0, 0, 32'h04));
    vecs.push_back(mk(OP_RD,   A_RXD, 0, 0, 32'hC3));
    vecs.push_back(mk(OP_RD,   A_RXD, 0, 0, 32'h00));
    vecs.push_back(mk(OP_RXRD, A_RXD, 0, 8'hD0, 32'h00));
    vecs.push_back(mk(OP_RD,   A_RXD, 0, 0, 32'hD0));
    vecs.push_back(mk(OP_RD,   A_RXD, 0, 0, 32'h00));
    for (int k = 1; k <= 4; k++) vecs.push_back(mk(OP_RX, 0, 0, 8'hE0 + 8'(k), 0));
    vecs.push_back(mk(OP_RXWR, A_CON, 32'h08, 8'hE5, 0));
    vecs.push_back(mk(OP_RD,   A_CON, 0, 0, 32'h0C));
    for (int k = 1; k <= 4; k++) vecs.push_back(mk(OP_RD, A_RXD, 0, 0, 32'hE0 + k));
    vecs.push_back(mk(OP_RD,   A_RXD, 0, 0, 32'h00));
    vecs.push_back(mk(OP_RD,   A_CON, 0, 0, 32'h08));
    vecs.push_back(mk(OP_WR,   A_CON, 32'h08, 0, 0));
    vecs.push_back(mk(OP_RD,   A_CON, 0, 0, 32'h00));
    vecs.push_back(mk(OP_WR,   A_CON, 32'h30, 0, 0));
    vecs.push_back(mk(OP_RD,   A_CON, 0, 0, EN_BITS));
    vecs.push_back(mk(OP_WR,   A_CON, 32'h7F, 0, 0));
    vecs.push_back(mk(OP_RD,   A_CON, 0, 0, EN_BITS));
    vecs.push_back(mk(OP_WR,   A_CON, 32'h00, 0, 0));
    vecs.push_back(mk(OP_RD,   A_CON, 0, 0, 32'h00));

    repeat (3) tick();
    rst = 1'b0;
    check("reset_tx_en", {31'd0, tx_en}, 32'd0);
    check("reset_tx_data", {24'd0, tx_data}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);

    run_table();

    // Single byte: tx_en one cycle after the write, exactly once.
    bus_write(A_TXD, 32'h55);
    check("t55_en", {31'd0, tx_en}, 32'd1);
    check("t55_data", {24'd0, tx_data}, 32'h55);
    peek("t55_con_start", A_CON, 32'h03);
    check("t55_en_off", {31'd0, tx_en}, 32'd0);
    peek("t55_con_wait", A_CON, 32'h02);
    expect_no_tx("t55_no_repeat", 3);
    check("t55_data_hold", {24'd0, tx_data}, 32'h55);
    pulse_done();
    peek("t55_con_done", A_CON, DONE);
    bus_write(A_CON, 32'h40);
    peek("t55_con_clr", A_CON, 32'h00);

    // Double buffering: 0x22 held during WAIT, 0x33 dropped.
    bus_write(A_TXD, 32'h11);
    check("t11_en", {31'd0, tx_en}, 32'd1);
    tick();
    bus_write(A_TXD, 32'h22);
    bus_write(A_TXD, 32'h33);
    check("t11_data_hold", {24'd0, tx_data}, 32'h11);
    check("t11_en_off", {31'd0, tx_en}, 32'd0);
    peek("t11_con_wait", A_CON, 32'h03);
    pulse_done();
    check("t22_idle_en", {31'd0, tx_en}, 32'd0);
    tick();
    check("t22_en", {31'd0, tx_en}, 32'd1);
    check("t22_data", {24'd0, tx_data}, 32'h22);
    peek("t22_con_start", A_CON, 32'h03 | DONE);
    check("t22_en_off", {31'd0, tx_en}, 32'd0);
    expect_no_tx("t22_wait", 2);
    pulse_done();
    expect_no_tx("t33_dropped", 4);
    peek("t33_con", A_CON, DONE);
    bus_write(A_CON, 32'h40);
    peek("t33_con_clr", A_CON, 32'h00);

`ifdef UART_IRQ_EN
    bus_write(A_CON, 32'h10);
    rx_pulse(8'h7E);
    check("irq_rx_latency", {31'd0, irq}, 32'd0);
    tick();
    check("irq_rx_high", {31'd0, irq}, 32'd1);
    peek("irq_rx_read", A_RXD, 32'h7E);
    tick();
    check("irq_rx_low", {31'd0, irq}, 32'd0);
    bus_write(A_CON, 32'h20);
    pulse_done();
    tick();
    check("irq_tx_high", {31'd0, irq}, 32'd1);
    bus_write(A_CON, 32'h40);
    tick();
    check("irq_tx_low", {31'd0, irq}, 32'd0);
    peek("irq_con_clr", A_CON, 32'h00);
`else
    bus_write(A_CON, 32'h30);
    rx_pulse(8'h7E);
    tick();
    check("irq_tied_rx", {31'd0, irq}, 32'd0);
    peek("irq_con_masked", A_CON, 32'h04);
    pulse_done();
    tick();
    check("irq_tied_tx", {31'd0, irq}, 32'd0);
    peek("irq_rx_read", A_RXD, 32'h7E);
    peek("irq_con_clr", A_CON, 32'h00);
`endif

    // Reset while waiting for tx_done abandons the frame and held byte.
    bus_write(A_TXD, 32'hA5);
    tick();
    bus_write(A_TXD, 32'h5A);
    rx_pulse(8'h99);
    check("rst_pre_data", {24'd0, tx_data}, 32'hA5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_tx_en", {31'd0, tx_en}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    peek("rst_con", A_CON, 32'h00);
    peek("rst_rxd", A_RXD, 32'h00);
    pulse_done();
    expect_no_tx("rst_late_done", 4);
    peek("rst_con_done", A_CON, DONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
